addr_gen_seq: RTL and testbench
===============================

ADDR_GEN_SEQ -- requirements
Module: addr_gen_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: width of o_addr.
REQ-002 SHALL have parameter ROW_LEN, default 53: addresses per row (burst).
REQ-003 SHALL have parameter ROWS, default 53: rows per pass.
REQ-004 SHALL have parameter PAUSE_LEN, default 2: idle cycles after each row except the final row of the sequence; 0 allowed.
REQ-005 SHALL have parameter REPEAT, default 1: cycles each address is held (prescaler); at least 1.
REQ-006 SHALL have parameter TIMESTEPS, default 7: passes per sequence.
REQ-007 SHALL have parameter PASS_STRIDE, default 0: address offset between passes; 0 replays the same addresses, as for weights.
REQ-008 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-009 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-010 SHALL have port en, input, 1 bit: advance enable; low freezes all state.
REQ-011 SHALL have port start, input, 1 bit: begins a sequence.
REQ-012 SHALL have port mode_rev, input, 1 bit: 0 = forward pass order, 1 = reverse pass order for BPTT.
REQ-013 SHALL have port o_addr, output, ADDR_WIDTH bits: generated address.
REQ-014 SHALL have port o_valid, output, 1 bit: o_addr is a live address.
REQ-015 SHALL have port o_row_last, output, 1 bit: o_addr is the last column of a row.
REQ-016 SHALL have port o_busy, output, 1 bit: a sequence is in progress.
REQ-017 SHALL have port o_done, output, 1 bit: one-cycle end-of-sequence pulse.

Function
REQ-018 SHALL register all outputs; there are no combinational input-to-output paths.
REQ-019 SHALL implement states IDLE, RUN, PAUSE and DONE.
REQ-020 SHALL, in IDLE with start=1 and en=1, sample mode_rev and enter RUN on the next edge with o_addr at the first address and o_valid=1.
REQ-021 SHALL ignore start while not in IDLE.
REQ-022 SHALL generate address = tbase + r*ROW_LEN + c, with c in 0..ROW_LEN-1 and r in 0..ROWS-1.
REQ-023 SHALL set tbase = t*PASS_STRIDE, where t runs 0..TIMESTEPS-1 when forward and TIMESTEPS-1..0 when reverse.
REQ-024 SHALL hold each address for exactly REPEAT enabled cycles.
REQ-025 SHALL, after the last hold of a row that is not the final row of the sequence, enter PAUSE for PAUSE_LEN enabled cycles, or go directly to the next address when PAUSE_LEN=0.
REQ-026 SHALL, in PAUSE, drive o_valid=0 and hold o_addr at the last address.
REQ-027 SHALL apply rows and passes identically at row boundaries: the pause after the last row of a pass also uses PAUSE_LEN.
REQ-028 SHALL assert o_row_last on every cycle of the last column of a row, including all of its REPEAT hold cycles.
REQ-029 SHALL, after the final address of the final pass, enter DONE for one cycle with o_done=1 and o_valid=0, then return to IDLE.
REQ-030 SHALL hold o_busy=1 in RUN, PAUSE and DONE, and o_busy=0 in IDLE.
REQ-031 SHALL, while en=0, hold every register (state, counters, outputs) unchanged; en=0 in IDLE blocks start.
REQ-032 SHALL accept start on the DONE cycle only after IDLE is reached, i.e. the earliest restart is one cycle later.
REQ-033 SHALL fail elaboration if (TIMESTEPS-1)*PASS_STRIDE + ROWS*ROW_LEN - 1 is 2^ADDR_WIDTH or more, or if REPEAT, ROW_LEN, ROWS or TIMESTEPS is 0.
REQ-034 SHALL size internal counters from the parameters, with no overflow for legal parameter values.

Reset
REQ-035 SHALL, on rst=1 at any time including mid-sequence, immediately force IDLE, zero all counters, and drive o_addr=0, o_valid=0, o_row_last=0, o_busy=0 and o_done=0.
REQ-036 SHALL, after rst deasserts, need a new start to begin a sequence; the interrupted sequence is not resumed.

Verification
REQ-037 SHALL be verified in forward mode with ROW_LEN=3, ROWS=2, PAUSE_LEN=2, REPEAT=1, TIMESTEPS=2, PASS_STRIDE=8 and en=1: valid addresses are 0,1,2 | 3,4,5 | 8,9,10 | 11,12,13, each bar being 2 invalid cycles.
REQ-038 SHALL be verified, for the REQ-037 case, to produce 18 cycles from first address to last, then o_done high for exactly 1 cycle, then o_busy=0.
REQ-039 SHALL be verified with the same parameters and mode_rev=1: 8,9,10 | 11,12,13 | 0,1,2 | 3,4,5.
REQ-040 SHALL be verified with REPEAT=2 and PAUSE_LEN=0: 0,0,1,1,2,2,3,3,... with no invalid gaps, and o_row_last high on both cycles of address 2.
REQ-041 SHALL be verified with en held low for 5 cycles while o_addr=4: o_addr, o_valid and state are unchanged, and the sequence resumes at 5.
REQ-042 SHALL be verified with rst pulsed while o_addr=9: outputs are 0 within the same cycle; start pulses while busy (before the rst) are ignored; and a new start after the rst restarts at address 0.

Source files
------------

// File: rtl/addr_gen_seq.sv
// Sequenced address generator: walks ROWS rows of ROW_LEN addresses per pass,
// TIMESTEPS passes per sequence, with per-address hold, inter-row pauses and
// forward or reverse pass order. All outputs come straight from flops.
module addr_gen_seq #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned ROW_LEN     = 53,
  parameter int unsigned ROWS        = 53,
  parameter int unsigned PAUSE_LEN   = 2,
  parameter int unsigned REPEAT      = 1,
  parameter int unsigned TIMESTEPS   = 7,
  parameter int unsigned PASS_STRIDE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  mode_rev,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_valid,
  output logic                  o_row_last,
  output logic                  o_busy,
  output logic                  o_done
);

  // Counter widths, at least one bit so degenerate sizes still elaborate.
  localparam int unsigned ColW   = (ROW_LEN > 1)   ? $clog2(ROW_LEN)   : 1;
  localparam int unsigned RowW   = (ROWS > 1)      ? $clog2(ROWS)      : 1;
  localparam int unsigned PassW  = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1;
  localparam int unsigned RepW   = (REPEAT > 1)    ? $clog2(REPEAT)    : 1;
  localparam int unsigned PauseW = (PAUSE_LEN > 1) ? $clog2(PAUSE_LEN) : 1;

  // Highest address the sequence can emit, computed in 64 bits.
  localparam longint unsigned PassSpan =
      (TIMESTEPS > 0) ? (64'(TIMESTEPS) - 64'd1) * 64'(PASS_STRIDE) : 64'd0;
  localparam longint unsigned PassLen  = 64'(ROWS) * 64'(ROW_LEN);
  localparam longint unsigned MaxAddr  = PassSpan + PassLen - 64'd1;
  localparam longint unsigned AddrSpace =
      (ADDR_WIDTH < 64) ? (64'd1 << ADDR_WIDTH) : 64'hFFFF_FFFF_FFFF_FFFF;

  if (REPEAT == 0 || ROW_LEN == 0 || ROWS == 0 || TIMESTEPS == 0 || ADDR_WIDTH == 0)
  begin : g_bad_zero
    $fatal(1, "addr_gen_seq: REPEAT, ROW_LEN, ROWS, TIMESTEPS, ADDR_WIDTH must be nonzero");
  end

  if (ADDR_WIDTH < 64 && MaxAddr >= AddrSpace) begin : g_bad_width
    $fatal(1, "addr_gen_seq: ADDR_WIDTH too narrow for the generated address range");
  end

  localparam logic [ColW-1:0]       ColLast   = ColW'(ROW_LEN - 1);
  localparam logic [RowW-1:0]       RowLast   = RowW'(ROWS - 1);
  localparam logic [PassW-1:0]      PassLast  = PassW'(TIMESTEPS - 1);
  localparam logic [RepW-1:0]       RepLast   = RepW'(REPEAT - 1);
  localparam logic [PauseW-1:0]     PauseLast = PauseW'((PAUSE_LEN > 0) ? PAUSE_LEN - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] Stride    = ADDR_WIDTH'(PASS_STRIDE);
  localparam logic [ADDR_WIDTH-1:0] LastBase  = ADDR_WIDTH'(PassSpan);
  // Single-column rows make every address the last column.
  localparam logic                  FirstIsLast = (ROW_LEN == 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [ColW-1:0]         col_q, col_d;
  logic [RowW-1:0]         row_q, row_d;
  logic [PassW-1:0]        pass_q, pass_d;
  logic [RepW-1:0]         rep_q, rep_d;
  logic [PauseW-1:0]       pause_q, pause_d;
  logic                    rev_q, rev_d;
  logic [ADDR_WIDTH-1:0]   tbase_q, tbase_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    valid_q, valid_d;
  logic                    row_last_q, row_last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Start-of-next-row values; rows are contiguous within a pass, so only a
  // pass change needs a jump to the next pass base.
  logic [RowW-1:0]         nxt_row;
  logic [PassW-1:0]        nxt_pass;
  logic [ADDR_WIDTH-1:0]   nxt_tbase;
  logic [ADDR_WIDTH-1:0]   nxt_addr;
  logic                    final_row;
  logic                    step_row;

  // Compute where the following row begins.
  always_comb begin
    nxt_row   = row_q;
    nxt_pass  = pass_q;
    nxt_tbase = tbase_q;
    nxt_addr  = addr_q + 1'b1;
    if (row_q == RowLast) begin
      nxt_row   = '0;
      nxt_pass  = pass_q + 1'b1;
      nxt_tbase = rev_q ? (tbase_q - Stride) : (tbase_q + Stride);
      nxt_addr  = nxt_tbase;
    end else begin
      nxt_row   = row_q + 1'b1;
    end
  end

  assign final_row = (row_q == RowLast) && (pass_q == PassLast);

  // Next-state and registered-output logic; en=0 leaves every register as is.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    pass_d     = pass_q;
    rep_d      = rep_q;
    pause_d    = pause_q;
    rev_d      = rev_q;
    tbase_d    = tbase_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    row_last_d = row_last_q;
    busy_d     = busy_q;
    done_d     = done_q;
    step_row   = 1'b0;

    if (en) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StRun;
            rev_d      = mode_rev;
            col_d      = '0;
            row_d      = '0;
            pass_d     = '0;
            rep_d      = '0;
            pause_d    = '0;
            tbase_d    = mode_rev ? LastBase : '0;
            addr_d     = mode_rev ? LastBase : '0;
            valid_d    = 1'b1;
            row_last_d = FirstIsLast;
            busy_d     = 1'b1;
            done_d     = 1'b0;
          end
        end

        StRun: begin
          if (rep_q != RepLast) begin
            rep_d = rep_q + 1'b1;
          end else if (col_q != ColLast) begin
            col_d      = col_q + 1'b1;
            rep_d      = '0;
            addr_d     = addr_q + 1'b1;
            row_last_d = (col_d == ColLast);
          end else if (final_row) begin
            state_d    = StDone;
            valid_d    = 1'b0;
            row_last_d = 1'b0;
            done_d     = 1'b1;
          end else if (PAUSE_LEN == 0) begin
            step_row = 1'b1;
          end else begin
            state_d    = StPause;
            valid_d    = 1'b0;
            row_last_d = 1'b0;
            pause_d    = '0;
          end
        end

        StPause: begin
          if (pause_q != PauseLast) begin
            pause_d = pause_q + 1'b1;
          end else begin
            state_d  = StRun;
            step_row = 1'b1;
          end
        end

        StDone: begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end

        default: begin
          state_d = StIdle;
        end
      endcase

      if (step_row) begin
        col_d      = '0;
        rep_d      = '0;
        row_d      = nxt_row;
        pass_d     = nxt_pass;
        tbase_d    = nxt_tbase;
        addr_d     = nxt_addr;
        valid_d    = 1'b1;
        row_last_d = FirstIsLast;
      end
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      pass_q     <= '0;
      rep_q      <= '0;
      pause_q    <= '0;
      rev_q      <= 1'b0;
      tbase_q    <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      row_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pass_q     <= pass_d;
      rep_q      <= rep_d;
      pause_q    <= pause_d;
      rev_q      <= rev_d;
      tbase_q    <= tbase_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      row_last_q <= row_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_addr     = addr_q;
  assign o_valid    = valid_q;
  assign o_row_last = row_last_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_addr_gen_seq.sv
// Bench for addr_gen_seq: instance A (pauses, REPEAT=1) and instance B
// (REPEAT=2, no pauses). Expected per-cycle output records are queued at start
// and compared on each falling edge.
module tb_addr_gen_seq;

  localparam int unsigned RL     = 3;
  localparam int unsigned NROWS  = 2;
  localparam int unsigned TS     = 2;
  localparam int unsigned STRIDE = 8;

  typedef struct {
    logic       valid;
    logic [7:0] addr;
    logic       row_last;
    logic       busy;
    logic       done;
    logic       chk_addr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, start_a, rev_a;
  logic       en_b, start_b, rev_b;
  logic [7:0] o_addr_a, o_addr_b;
  logic       o_valid_a, o_row_last_a, o_busy_a, o_done_a;
  logic       o_valid_b, o_row_last_b, o_busy_b, o_done_b;

  exp_t qa[$];
  exp_t qb[$];
  exp_t cur_a, cur_b;
  bit   have_a = 1'b0, have_b = 1'b0;
  bit   last_en_a = 1'b1, last_en_b = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  addr_gen_seq #(
    .ADDR_WIDTH(8), .ROW_LEN(RL), .ROWS(NROWS), .PAUSE_LEN(2), .REPEAT(1),
    .TIMESTEPS(TS), .PASS_STRIDE(STRIDE)
  ) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .start(start_a), .mode_rev(rev_a),
    .o_addr(o_addr_a), .o_valid(o_valid_a), .o_row_last(o_row_last_a),
    .o_busy(o_busy_a), .o_done(o_done_a)
  );

  addr_gen_seq #(
    .ADDR_WIDTH(8), .ROW_LEN(RL), .ROWS(NROWS), .PAUSE_LEN(0), .REPEAT(2),
    .TIMESTEPS(TS), .PASS_STRIDE(STRIDE)
  ) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .start(start_b), .mode_rev(rev_b),
    .o_addr(o_addr_b), .o_valid(o_valid_b), .o_row_last(o_row_last_b),
    .o_busy(o_busy_b), .o_done(o_done_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_rec(input string tag, input exp_t e, input logic v, input logic [7:0] a,
                         input logic rl, input logic b, input logic d);
    check_eq({tag, ".valid"}, 32'(v), 32'(e.valid));
    check_eq({tag, ".busy"}, 32'(b), 32'(e.busy));
    check_eq({tag, ".done"}, 32'(d), 32'(e.done));
    if (e.chk_addr) check_eq({tag, ".addr"}, 32'(a), 32'(e.addr));
    if (e.valid) check_eq({tag, ".row_last"}, 32'(rl), 32'(e.row_last));
  endtask

  task automatic push_rec(input bit sel_b, input exp_t e);
    if (sel_b) qb.push_back(e);
    else qa.push_back(e);
  endtask

  // Reference model: full per-cycle trace of one sequence from first address.
  task automatic push_trace(input bit sel_b, input bit rev);
    int   rep;
    int   pl;
    int   t;
    int   a;
    exp_t e;
    rep = sel_b ? 2 : 1;
    pl  = sel_b ? 0 : 2;
    a   = 0;
    for (int k = 0; k < int'(TS); k++) begin
      t = rev ? int'(TS) - 1 - k : k;
      for (int r = 0; r < int'(NROWS); r++) begin
        for (int c = 0; c < int'(RL); c++) begin
          a = t * int'(STRIDE) + r * int'(RL) + c;
          for (int h = 0; h < rep; h++) begin
            e.valid = 1'b1; e.addr = 8'(a); e.row_last = (c == int'(RL) - 1);
            e.busy = 1'b1; e.done = 1'b0; e.chk_addr = 1'b1;
            push_rec(sel_b, e);
          end
        end
        if (!(k == int'(TS) - 1 && r == int'(NROWS) - 1)) begin
          for (int p = 0; p < pl; p++) begin
            e.valid = 1'b0; e.addr = 8'(a); e.row_last = 1'b0;
            e.busy = 1'b1; e.done = 1'b0; e.chk_addr = 1'b1;
            push_rec(sel_b, e);
          end
        end
      end
    end
    e.valid = 1'b0; e.addr = 8'(a); e.row_last = 1'b0;
    e.busy = 1'b1; e.done = 1'b1; e.chk_addr = 1'b0;
    push_rec(sel_b, e);
    e.busy = 1'b0; e.done = 1'b0;
    push_rec(sel_b, e);
  endtask

  // Instance A monitor: advance the model only on cycles that had en high.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        have_a = 1'b0;
      end else if (last_en_a) begin
        if (qa.size() > 0) begin
          cur_a  = qa.pop_front();
          have_a = 1'b1;
          cmp_rec("run_a", cur_a, o_valid_a, o_addr_a, o_row_last_a, o_busy_a, o_done_a);
        end
      end else if (have_a) begin
        cmp_rec("hold_a", cur_a, o_valid_a, o_addr_a, o_row_last_a, o_busy_a, o_done_a);
      end
      last_en_a = en_a;
    end
  end

  // Instance B monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        have_b = 1'b0;
      end else if (last_en_b) begin
        if (qb.size() > 0) begin
          cur_b  = qb.pop_front();
          have_b = 1'b1;
          cmp_rec("run_b", cur_b, o_valid_b, o_addr_b, o_row_last_b, o_busy_b, o_done_b);
        end
      end else if (have_b) begin
        cmp_rec("hold_b", cur_b, o_valid_b, o_addr_b, o_row_last_b, o_busy_b, o_done_b);
      end
      last_en_b = en_b;
    end
  end

  task automatic start_run(input bit sel_b, input bit rev);
    if (sel_b) begin
      start_b = 1'b1; rev_b = rev;
    end else begin
      start_a = 1'b1; rev_a = rev;
    end
    @(posedge clk);
    push_trace(sel_b, rev);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    // mode_rev must only matter at start
    rev_a = !rev;
    rev_b = !rev;
  endtask

  task automatic wait_drain(input bit sel_b, input string tag);
    int i;
    i = 0;
    do begin
      @(posedge clk);
      i++;
    end while (((sel_b ? qb.size() : qa.size()) > 0) && i < 300);
    #1;
    check_eq(tag, 32'(sel_b ? qb.size() : qa.size()), 32'd0);
  endtask

  task automatic wait_addr_a(input logic [7:0] a, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (o_valid_a && o_addr_a == a) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".addr"}, 32'(o_addr_a), 32'd0);
    check_eq({tag, ".valid"}, 32'(o_valid_a), 32'd0);
    check_eq({tag, ".row_last"}, 32'(o_row_last_a), 32'd0);
    check_eq({tag, ".busy"}, 32'(o_busy_a), 32'd0);
    check_eq({tag, ".done"}, 32'(o_done_a), 32'd0);
    check_eq({tag, ".busy_b"}, 32'(o_busy_b), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    en_a = 1'b1; start_a = 1'b0; rev_a = 1'b0;
    en_b = 1'b1; start_b = 1'b0; rev_b = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Forward, reverse, then hold/no-pause instance.
    start_run(1'b0, 1'b0);
    wait_drain(1'b0, "drain_fwd");
    start_run(1'b0, 1'b1);
    wait_drain(1'b0, "drain_rev");
    start_run(1'b1, 1'b0);
    wait_drain(1'b1, "drain_rep");

    // Freeze for 5 cycles at address 4.
    start_run(1'b0, 1'b0);
    wait_addr_a(8'd4, "reach4");
    en_a = 1'b0;
    repeat (5) @(posedge clk);
    #1 en_a = 1'b1;
    wait_drain(1'b0, "drain_freeze");

    // en low in IDLE blocks start.
    en_a = 1'b0;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    check_eq("idle_en_low.busy", 32'(o_busy_a), 32'd0);
    en_a = 1'b1;
    @(posedge clk);
    #1 check_eq("idle_after.busy", 32'(o_busy_a), 32'd0);
    check_eq("idle_after.valid", 32'(o_valid_a), 32'd0);

    // Start while busy is ignored; reset mid-run at address 9; clean restart.
    start_run(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    wait_addr_a(8'd9, "reach9");
    #2 rst = 1'b1;
    qa.delete();
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check_eq("post_rst.busy", 32'(o_busy_a), 32'd0);
    start_run(1'b0, 1'b0);
    wait_drain(1'b0, "drain_restart");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
